// File: rtl/ne2000_pkg.sv
// ne2000_pkg: shared types and constants for the NE2000 receive path
package ne2000_pkg;
   typedef enum logic [2:0] {IDLE, DATA, HDR, COMMIT, DROP} state_t;
   localparam logic [7:0] RSR_RX_OK = 8'h01;
   localparam int HDR_LEN = 4;
   localparam int PAGE_SIZE = 256;
endpackage

// File: rtl/ne_ring_page_inc.sv
// ne_ring_page_inc: next page in the receive ring, wrapping pstop back to pstart
module ne_ring_page_inc (
   input  logic [7:0] p,
   input  logic [7:0] pstart,
   input  logic [7:0] pstop,
   output logic [7:0] q
);
   logic [7:0] p1;
   assign p1 = p + 8'd1;
   assign q = (p1 == pstop) ? pstart : p1;
endmodule

// File: rtl/ne_rx_ring_ctrl.sv
// ne_rx_ring_ctrl: streams received frames into the NE2000 page ring, then writes
// the 4-byte packet header in front of the payload and advances curr
module ne_rx_ring_ctrl
   import ne2000_pkg::*;
#(
   parameter int MIN_FRAME = 60,
   parameter int MAX_FRAME = 1518
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  pstart,
   input  logic [7:0]  pstop,
   input  logic [7:0]  bnry,
   input  logic        curr_wr,
   input  logic [7:0]  curr_din,
   input  logic        rx_begin,
   input  logic        rx_strobe,
   input  logic [7:0]  rx_byte,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic [7:0]  curr,
   output logic        prx,
   output logic        ovw,
   output logic        rxe,
   output logic        busy
);
   state_t      state;
   logic        rx_q;
   logic [15:0] wptr;
   logic [15:0] len;
   logic [7:0]  start_page;
   logic [7:0]  next_page;
   logic [1:0]  cnt;
   logic [7:0]  pg_adv;
   logic [7:0]  pg_end;
   logic [7:0]  hdr_byte;
   logic        rise;
   logic        fall;
   logic        at_max;
   logic        page_end;
   logic        wr_data;

   ne_ring_page_inc u_inc_adv (.p(wptr[15:8]), .pstart(pstart), .pstop(pstop), .q(pg_adv));
   ne_ring_page_inc u_inc_end (.p(wptr[15:8]), .pstart(pstart), .pstop(pstop), .q(pg_end));

   assign rise     = rx_begin & ~rx_q;
   assign fall     = ~rx_begin & rx_q;
   assign at_max   = len == 16'(MAX_FRAME);
   assign page_end = wptr[7:0] == 8'(PAGE_SIZE - 1);
   assign wr_data  = (state == DATA) & rx_strobe & ~fall & ~at_max;
   assign hdr_byte = (cnt == 2'd0) ? RSR_RX_OK :
                     (cnt == 2'd1) ? next_page :
                     (cnt == 2'd2) ? len[7:0] : len[15:8];
   // the RAM port is held quiet during reset so an interrupted header leaves no stray byte
   assign mem_we    = ~reset & (wr_data | (state == HDR));
   assign mem_addr  = ~mem_we ? 16'h0000 : (state == HDR) ? {start_page, 6'd0, cnt} : wptr;
   assign mem_wdata = ~mem_we ? 8'h00 : (state == HDR) ? hdr_byte : rx_byte;
   assign busy      = state != IDLE;

   always_ff @(posedge clk) begin
      rx_q <= rx_begin;
      if (reset) begin
         state      <= IDLE;
         curr       <= 8'h00;
         prx        <= 1'b0;
         ovw        <= 1'b0;
         rxe        <= 1'b0;
         wptr       <= 16'h0000;
         start_page <= 8'h00;
         len        <= 16'h0000;
         next_page  <= 8'h00;
         cnt        <= 2'd0;
      end else begin
         prx <= 1'b0;
         ovw <= 1'b0;
         rxe <= 1'b0;
         if (curr_wr)
            curr <= curr_din;
         case (state)
            IDLE:
               if (rise) begin
                  if (pstart >= pstop) begin
                     rxe   <= 1'b1;
                     state <= DROP;
                  end else begin
                     start_page <= curr;
                     wptr       <= {curr, 8'(HDR_LEN)};
                     len        <= 16'h0000;
                     state      <= DATA;
                  end
               end
            DATA:
               if (fall) begin
                  if (len < 16'(MIN_FRAME)) begin
                     rxe   <= 1'b1;
                     state <= IDLE;
                  end else begin
                     next_page <= (wptr[7:0] == 8'h00) ? wptr[15:8] : pg_end;
                     cnt       <= 2'd0;
                     state     <= HDR;
                  end
               end else if (rx_strobe) begin
                  if (at_max) begin
                     rxe   <= 1'b1;
                     state <= DROP;
                  end else begin
                     len <= len + 16'd1;
                     if (!page_end)
                        wptr <= wptr + 16'd1;
                     else if (pg_adv == bnry) begin
                        ovw   <= 1'b1;
                        state <= DROP;
                     end else
                        wptr <= {pg_adv, 8'h00};
                  end
               end
            HDR: begin
               cnt <= cnt + 2'd1;
               if (cnt == 2'(HDR_LEN - 1))
                  state <= COMMIT;
            end
            COMMIT: begin
               curr  <= next_page;
               prx   <= 1'b1;
               state <= IDLE;
            end
            DROP:
               if (!rx_begin)
                  state <= IDLE;
            default:
               state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ne_rx_ring_ctrl.sv
// tb_ne_rx_ring_ctrl: scoreboard bench for the receive ring sequencer
module tb_ne_rx_ring_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  pstart = 8'h00, pstop = 8'h00, bnry = 8'h00, curr_din = 8'h00, rx_byte = 8'h00;
   logic        curr_wr = 1'b0, rx_begin = 1'b0, rx_strobe = 1'b0;
   logic        mem_we, prx, ovw, rxe, busy;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, curr;
   int n_chk = 0, n_pass = 0, n_wr = 0, n_prx = 0, n_ovw = 0, n_rxe = 0;
   int cyc = 0, prx_cyc = 0, fall_cyc = 0;
   logic [23:0] exp_q[$];
   logic [7:0]  mem_img [logic [15:0]];
   logic        m_ok;
   logic [7:0]  m_pg, m_off, m_start;
   logic [15:0] m_len;

   ne_rx_ring_ctrl dut (
      .clk(clk), .reset(reset), .pstart(pstart), .pstop(pstop), .bnry(bnry),
      .curr_wr(curr_wr), .curr_din(curr_din), .rx_begin(rx_begin), .rx_strobe(rx_strobe),
      .rx_byte(rx_byte), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .curr(curr), .prx(prx), .ovw(ovw), .rxe(rxe), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] inc(input logic [7:0] p);
      logic [7:0] p1;
      p1 = p + 8'd1;
      return (p1 == pstop) ? pstart : p1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      logic [23:0] e;
      forever begin
         @(negedge clk);
         if (mem_we) begin
            mem_img[mem_addr] = mem_wdata;
            n_wr++;
            n_chk++;
            if (exp_q.size() == 0)
               $display("FAIL sb_unexpected: write %h=%h with nothing expected", mem_addr, mem_wdata);
            else begin
               e = exp_q.pop_front();
               if ({mem_addr, mem_wdata} !== e)
                  $display("FAIL sb_write: got %h=%h want %h=%h", mem_addr, mem_wdata, e[23:8], e[7:0]);
               else
                  n_pass++;
            end
         end
         if (prx) begin
            n_prx++;
            prx_cyc = cyc;
         end
         if (ovw) n_ovw++;
         if (rxe) n_rxe++;
      end
   endtask

   task automatic set_curr(input logic [7:0] v);
      curr_wr = 1'b1;
      curr_din = v;
      step();
      curr_wr = 1'b0;
   endtask

   // a strobe is raised in the rising-edge cycle; it must not be written
   task automatic start_frame(input logic [7:0] c);
      m_ok = pstart < pstop;
      m_start = c;
      m_pg = c;
      m_off = 8'h04;
      m_len = 16'h0000;
      rx_begin = 1'b1;
      rx_strobe = 1'b1;
      rx_byte = 8'hEE;
      step();
      rx_strobe = 1'b0;
   endtask

   task automatic send_bytes(input int n);
      for (int i = 0; i < n; i++) begin
         rx_byte = 8'($urandom);
         rx_strobe = 1'b1;
         if (m_ok) begin
            if (m_len == 16'd1518)
               m_ok = 1'b0;
            else begin
               exp_q.push_back({m_pg, m_off, rx_byte});
               m_len++;
               if (m_off == 8'hFF) begin
                  if (inc(m_pg) == bnry)
                     m_ok = 1'b0;
                  else begin
                     m_pg = inc(m_pg);
                     m_off = 8'h00;
                  end
               end else
                  m_off++;
            end
         end
         step();
         rx_strobe = 1'b0;
         repeat ($urandom_range(0, 1)) step();
      end
   endtask

   task automatic end_frame(input int cw_at);
      logic [7:0] np;
      rx_begin = 1'b0;
      fall_cyc = cyc;
      if (m_ok && m_len >= 16'd60) begin
         np = (m_off == 8'h00) ? m_pg : inc(m_pg);
         exp_q.push_back({m_start, 8'h00, 8'h01});
         exp_q.push_back({m_start, 8'h01, np});
         exp_q.push_back({m_start, 8'h02, m_len[7:0]});
         exp_q.push_back({m_start, 8'h03, m_len[15:8]});
      end
      for (int i = 0; i < 8; i++) begin
         if (i == cw_at) begin
            curr_wr = 1'b1;
            curr_din = 8'h55;
         end
         step();
         curr_wr = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      n_chk++; if (curr !== 8'h00) $display("FAIL reset_curr: got %h want 00", curr); else n_pass++;
      n_chk++; if ({busy, prx, ovw, rxe, mem_we} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {busy, prx, ovw, rxe, mem_we}); else n_pass++;
      n_chk++; if ({mem_addr, mem_wdata} !== 24'h0) $display("FAIL reset_mem: got %h want 000000", {mem_addr, mem_wdata}); else n_pass++;
      reset = 1'b0;
      step();
      n_chk++; if (busy !== 1'b0) $display("FAIL reset_idle: busy got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_basic();
      int p0;
      pstart = 8'h46; pstop = 8'h60; bnry = 8'h46;
      set_curr(8'h47);
      n_chk++; if (curr !== 8'h47) $display("FAIL basic_setcurr: got %h want 47", curr); else n_pass++;
      mem_img.delete();
      p0 = n_prx;
      start_frame(8'h47);
      send_bytes(100);
      n_chk++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
      end_frame(-1);
      n_chk++; if (n_prx - p0 !== 1) $display("FAIL basic_prx: got %0d want 1", n_prx - p0); else n_pass++;
      n_chk++; if (prx_cyc - fall_cyc !== 6) $display("FAIL basic_latency: got %0d want 6", prx_cyc - fall_cyc); else n_pass++;
      n_chk++; if (curr !== 8'h48) $display("FAIL basic_curr: got %h want 48", curr); else n_pass++;
      n_chk++; if ({mem_img[16'h4700], mem_img[16'h4701], mem_img[16'h4702], mem_img[16'h4703]} !== 32'h01486400)
         $display("FAIL basic_hdr: got %h%h%h%h want 01486400", mem_img[16'h4700], mem_img[16'h4701], mem_img[16'h4702], mem_img[16'h4703]); else n_pass++;
      n_chk++; if (!mem_img.exists(16'h4767) || mem_img.exists(16'h4768)) $display("FAIL basic_span: last payload byte not at 4767"); else n_pass++;
      n_chk++; if (exp_q.size() !== 0) $display("FAIL basic_pending: got %0d want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_wrap();
      bnry = 8'h50;
      set_curr(8'h5F);
      mem_img.delete();
      start_frame(8'h5F);
      send_bytes(600);
      end_frame(-1);
      n_chk++; if (!mem_img.exists(16'h5FFF) || !mem_img.exists(16'h4600)) $display("FAIL wrap_addr: 5FFF/4600 not both written"); else n_pass++;
      n_chk++; if ({mem_img[16'h5F00], mem_img[16'h5F01], mem_img[16'h5F02], mem_img[16'h5F03]} !== 32'h01485802)
         $display("FAIL wrap_hdr: got %h%h%h%h want 01485802", mem_img[16'h5F00], mem_img[16'h5F01], mem_img[16'h5F02], mem_img[16'h5F03]); else n_pass++;
      n_chk++; if (curr !== 8'h48) $display("FAIL wrap_curr: got %h want 48", curr); else n_pass++;
      n_chk++; if (exp_q.size() !== 0) $display("FAIL wrap_pending: got %0d want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_overflow();
      int p0, o0, r0;
      bnry = 8'h49;
      set_curr(8'h47);
      mem_img.delete();
      p0 = n_prx; o0 = n_ovw; r0 = n_rxe;
      start_frame(8'h47);
      send_bytes(1000);
      n_chk++; if (n_ovw - o0 !== 1) $display("FAIL ovf_pulse: got %0d want 1", n_ovw - o0); else n_pass++;
      n_chk++; if (busy !== 1'b1) $display("FAIL ovf_busy_held: got %b want 1", busy); else n_pass++;
      n_chk++; if (!mem_img.exists(16'h48FF) || mem_img.exists(16'h4900)) $display("FAIL ovf_stop: writes did not stop at 48FF"); else n_pass++;
      end_frame(-1);
      n_chk++; if (busy !== 1'b0) $display("FAIL ovf_busy_end: got %b want 0", busy); else n_pass++;
      n_chk++; if (mem_img.exists(16'h4700)) $display("FAIL ovf_nohdr: header byte written at 4700"); else n_pass++;
      n_chk++; if (curr !== 8'h47) $display("FAIL ovf_curr: got %h want 47", curr); else n_pass++;
      n_chk++; if ((n_prx - p0) + (n_rxe - r0) !== 0) $display("FAIL ovf_excl: prx+rxe got %0d want 0", (n_prx - p0) + (n_rxe - r0)); else n_pass++;
   endtask

   task automatic test_runt_oversize();
      int p0, r0, w0;
      bnry = 8'h46;
      mem_img.delete();
      p0 = n_prx; r0 = n_rxe;
      start_frame(8'h47);
      send_bytes(59);
      end_frame(-1);
      n_chk++; if (n_rxe - r0 !== 1) $display("FAIL runt_rxe: got %0d want 1", n_rxe - r0); else n_pass++;
      n_chk++; if (n_prx - p0 !== 0) $display("FAIL runt_prx: got %0d want 0", n_prx - p0); else n_pass++;
      n_chk++; if (curr !== 8'h47 || mem_img.exists(16'h4700)) $display("FAIL runt_state: curr %h, header present %0d", curr, mem_img.exists(16'h4700)); else n_pass++;
      r0 = n_rxe; w0 = n_wr;
      start_frame(8'h47);
      send_bytes(1519);
      end_frame(-1);
      n_chk++; if (n_wr - w0 !== 1518) $display("FAIL big_writes: got %0d want 1518", n_wr - w0); else n_pass++;
      n_chk++; if (n_rxe - r0 !== 1) $display("FAIL big_rxe: got %0d want 1", n_rxe - r0); else n_pass++;
      n_chk++; if (n_prx - p0 !== 0 || curr !== 8'h47) $display("FAIL big_state: prx %0d curr %h want 0 47", n_prx - p0, curr); else n_pass++;
      mem_img.delete();
      start_frame(8'h47);
      send_bytes(60);
      end_frame(-1);
      n_chk++; if (curr !== 8'h48 || mem_img[16'h4702] !== 8'h3C) $display("FAIL min_frame: curr %h len %h want 48 3C", curr, mem_img[16'h4702]); else n_pass++;
      mem_img.delete();
      start_frame(8'h48);
      send_bytes(1518);
      end_frame(-1);
      n_chk++; if ({mem_img[16'h4800], mem_img[16'h4801], mem_img[16'h4802], mem_img[16'h4803]} !== 32'h014EEE05)
         $display("FAIL max_hdr: got %h%h%h%h want 014EEE05", mem_img[16'h4800], mem_img[16'h4801], mem_img[16'h4802], mem_img[16'h4803]); else n_pass++;
      n_chk++; if (curr !== 8'h4E) $display("FAIL max_curr: got %h want 4E", curr); else n_pass++;
      n_chk++; if (exp_q.size() !== 0) $display("FAIL size_pending: got %0d want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_curr_wr();
      int p0;
      set_curr(8'h47);
      mem_img.delete();
      start_frame(8'h47);
      send_bytes(30);
      set_curr(8'h50);
      n_chk++; if (curr !== 8'h50) $display("FAIL cw_mid: got %h want 50", curr); else n_pass++;
      send_bytes(70);
      end_frame(-1);
      n_chk++; if (mem_img[16'h4700] !== 8'h01 || mem_img[16'h4701] !== 8'h48) $display("FAIL cw_hdr: got %h %h want 01 48", mem_img[16'h4700], mem_img[16'h4701]); else n_pass++;
      n_chk++; if (curr !== 8'h48) $display("FAIL cw_commit: got %h want 48", curr); else n_pass++;
      p0 = n_prx;
      start_frame(8'h48);
      send_bytes(100);
      end_frame(5);
      n_chk++; if (curr !== 8'h49) $display("FAIL cw_collide: got %h want 49", curr); else n_pass++;
      n_chk++; if (n_prx - p0 !== 1) $display("FAIL cw_prx: got %0d want 1", n_prx - p0); else n_pass++;
   endtask

   task automatic test_reset_hdr();
      int p0, r0, w0;
      p0 = n_prx;
      start_frame(8'h49);
      send_bytes(70);
      rx_begin = 1'b0;
      exp_q.push_back({8'h49, 8'h00, 8'h01});
      repeat (2) step();
      reset = 1'b1;
      step();
      n_chk++; if ({mem_we, mem_addr, mem_wdata} !== 25'h0) $display("FAIL rsthdr_mem: got %h want 0", {mem_we, mem_addr, mem_wdata}); else n_pass++;
      n_chk++; if ({curr, busy, prx, ovw, rxe} !== 12'h0) $display("FAIL rsthdr_out: got %h want 000", {curr, busy, prx, ovw, rxe}); else n_pass++;
      repeat (4) step();
      reset = 1'b0;
      step();
      n_chk++; if (n_prx - p0 !== 0) $display("FAIL rsthdr_prx: got %0d want 0", n_prx - p0); else n_pass++;
      n_chk++; if (exp_q.size() !== 0) $display("FAIL rsthdr_pending: got %0d want 0", exp_q.size()); else n_pass++;
      rx_begin = 1'b1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (3) step();
      n_chk++; if (busy !== 1'b0) $display("FAIL rst_level_high: busy got %b want 0", busy); else n_pass++;
      rx_begin = 1'b0;
      step();
      pstart = 8'h40; pstop = 8'h40;
      r0 = n_rxe; w0 = n_wr; p0 = n_prx;
      start_frame(8'h00);
      send_bytes(5);
      n_chk++; if (n_rxe - r0 !== 1 || busy !== 1'b1) $display("FAIL badcfg_rxe: rxe %0d busy %b want 1 1", n_rxe - r0, busy); else n_pass++;
      end_frame(-1);
      n_chk++; if (n_wr - w0 !== 0 || n_prx - p0 !== 0) $display("FAIL badcfg_quiet: writes %0d prx %0d want 0 0", n_wr - w0, n_prx - p0); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL badcfg_idle: busy got %b want 0", busy); else n_pass++;
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_wrap();
      test_overflow();
      test_runt_oversize();
      test_curr_wr();
      test_reset_hdr();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ne_rx_ring_ctrl.md
Name: ne_rx_ring_ctrl

Overview:
- Receive-side sequencer for the NE2000 emulation. Places incoming frames from the io controller into the 256-byte-page receive ring bounded by pstart/pstop.
- Owns the curr page pointer and drives the rx buffer write port (address, data, enable).
- Writes the 4-byte NE2000 packet header after the payload, then raises PRX. Drops runt, oversize and overflowing frames.
- Sits between the io-controller byte stream and the rx buffer RAM. The CPU register block supplies pstart/pstop/bnry and consumes curr and the interrupt pulses.

Parameters:
MIN_FRAME, 60, payload bytes below this are a runt and are dropped
MAX_FRAME, 1518, payload bytes above this are oversize and are dropped

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pstart  in  8  ring start page
pstop  in  8  ring stop page (exclusive)
bnry  in  8  boundary page, the oldest unread page
curr_wr  in  1  CPU write strobe for curr (1 cycle)
curr_din  in  8  CPU curr value
rx_begin  in  1  level; high while an io-controller frame is streaming (already synchronised)
rx_strobe  in  1  1-cycle pulse per payload byte
rx_byte  in  8  payload byte, valid with rx_strobe
mem_we  out  1  rx buffer write enable
mem_addr  out  16  rx buffer byte address, {page, offset}
mem_wdata  out  8  rx buffer write data
curr  out  8  current page register
prx  out  1  1-cycle pulse: frame committed
ovw  out  1  1-cycle pulse: ring overflow, frame dropped
rxe  out  1  1-cycle pulse: runt, oversize or bad configuration, frame dropped
busy  out  1  state != IDLE

Behaviour:
Reset:
- State IDLE. All outputs 0, including curr = 8'h00.
- Internal registers: wptr, start_page and len cleared.

Helper function: inc(p) = (p+1 == pstop) ? pstart : p+1, computed in 8 bits.

IDLE:
- Rising edge of rx_begin (registered compare) starts a frame.
- If pstart >= pstop: go to DROP and pulse rxe.
- Otherwise: start_page <= curr, wptr <= {curr, 8'h04}, len <= 0, go to DATA.
- An rx_strobe in the same cycle as the rising edge is ignored.

DATA:
- Each rx_strobe, same cycle: mem_we=1, mem_addr=wptr, mem_wdata=rx_byte. Next cycle: len+1 and wptr advances.
- When wptr[7:0] == 8'hFF, the next wptr is {inc(wptr[15:8]), 8'h00}.
- If inc(wptr[15:8]) == bnry: the write of the current byte still happens; then pulse ovw, go to DROP, curr unchanged.
- If a strobe arrives with len == MAX_FRAME: no write, pulse rxe, go to DROP.
- Falling edge of rx_begin:
  - len < MIN_FRAME: pulse rxe, go to IDLE.
  - Otherwise: compute next_page = (wptr[7:0] == 0) ? wptr[15:8] : inc(wptr[15:8]), go to HDR.

HDR (4 cycles, cnt 0..3):
- mem_we=1, mem_addr={start_page, cnt}.
- mem_wdata in order: 8'h01 (RSR: rx ok), next_page, len[7:0], len[15:8].
- rx_strobe is ignored.
- After cnt 3, go to COMMIT.

COMMIT (1 cycle):
- curr <= next_page, prx=1, go to IDLE.
- Latency from rx_begin falling to prx: 6 cycles (edge detect, then 4 header cycles, then commit).

DROP:
- No writes; strobes are ignored.
- On rx_begin low, return to IDLE (no further pulse). curr unchanged.

curr_wr:
- Loads curr_din in any state.
- An in-flight frame keeps its latched start_page; COMMIT overwrites curr.
- If curr_wr and COMMIT fall in the same cycle, COMMIT wins.

reset mid-frame: returns to IDLE immediately with outputs cleared. A later rx_begin that is already high is not treated as a rising edge.

prx, ovw and rxe are mutually exclusive per frame.

Width rules:
- len is 16 bits and saturates by construction at MAX_FRAME.
- wptr is 16 bits; the page field is always within [pstart, pstop).

Decomposition:
- Shared package ne2000_pkg:
  - state enum (IDLE, DATA, HDR, COMMIT, DROP)
  - RSR_RX_OK = 8'h01
  - HDR_LEN = 4
  - PAGE_SIZE = 256
- One natural sub-module: ne_ring_page_inc, the combinational inc(p) given pstart/pstop. It is instanced twice, for wptr advance and for next_page.

Test Plan:
1. pstart=0x46, pstop=0x60, bnry=0x46, curr=0x47; stream 100 bytes -> payload at 0x4704..0x4767; header at 0x4700 = 01,48,64,00; curr=0x48; one prx 6 cycles after rx_begin falls.
2. curr=0x5F, same ring, 600-byte frame -> writes wrap 0x5FFF to 0x4600; header next_page=0x48, len=0x0258; curr=0x48.
3. bnry=0x49, curr=0x47, 1000-byte frame -> ovw pulse on the strobe that would cross into 0x49; no header written; curr stays 0x47; busy held until rx_begin falls.
4. 59-byte frame -> rxe, no prx, curr unchanged. 1519-byte frame -> 1518 bytes written, then rxe, curr unchanged.
5. curr_wr=0x50 mid-frame (start 0x47) -> header still at 0x4700; curr ends at the computed next_page. curr_wr in the same cycle as COMMIT -> COMMIT value kept.
6. reset asserted during HDR -> all outputs 0 next cycle, no prx. pstart=pstop=0x40 -> rx_begin rise gives rxe and no writes.
